// File: rtl/btn_pkg.sv
// Shared types and constants for the button pulse generator: selector width,
// FSM state encoding and the wrap-around step-count helper.
package btn_pkg;

  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    DONE
  } state_t;

  // Presses needed to walk a modulo-2^SEL_W selector forward from cur to target.
  function automatic sel_t sel_steps(input sel_t target, input sel_t cur);
    return target - cur;
  endfunction

endpackage

// File: rtl/btn_pulse_gen_if.sv
// Request/status bundle between a requester (master) and btn_pulse_gen (slave).
interface btn_pulse_gen_if;
  import btn_pkg::*;

  logic start;
  sel_t target;
  logic btn;
  sel_t cur_sel;
  logic busy;
  logic done;

  modport master (output start, target, input btn, cur_sel, busy, done);
  modport slave  (input start, target, output btn, cur_sel, busy, done);

endinterface

// File: rtl/btn_pulse_gen_phase_timer.sv
// Phase timer: cleared by load, counts while enabled, flags the last cycle of a phase.
module phase_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          count_en,
  input  logic [TW-1:0] last,
  output logic          expire
);

  logic [TW-1:0] count;

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

  assign expire = count_en && (count == last);

endmodule

// File: rtl/btn_pulse_gen.sv
// Steps a downstream selector to a target value by issuing timed btn presses.
// Optional abort input enabled by defining BTN_PULSE_GEN_ABORT_EN.
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int HIGH_CYC = 4,
  parameter int LOW_CYC  = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef BTN_PULSE_GEN_ABORT_EN
  input  logic abort,
`endif
  btn_pulse_gen_if.slave bus
);

  localparam int MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_t        state, state_nx;
  sel_t          steps, steps_nx;
  sel_t          cur_sel_q, cur_sel_nx;
  logic          btn_q;
  logic          timer_load, timer_en, timer_expire;
  logic [TW-1:0] timer_last;
  logic          stop_now;

`ifdef BTN_PULSE_GEN_ABORT_EN
  // An abort seen anywhere in a press is remembered until its LOW phase ends.
  logic abort_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      abort_q <= 1'b0;
    end else if ((state == HIGH || state == LOW) && abort) begin
      abort_q <= 1'b1;
    end else if (state == IDLE || state == DONE) begin
      abort_q <= 1'b0;
    end
  end

  assign stop_now = abort_q || abort;
`else
  assign stop_now = 1'b0;
`endif

  assign timer_en   = (state == HIGH) || (state == LOW);
  assign timer_load = (state_nx != state);
  assign timer_last = (state == HIGH) ? TW'(HIGH_CYC - 1) : TW'(LOW_CYC - 1);

  phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .count_en (timer_en),
    .last     (timer_last),
    .expire   (timer_expire)
  );

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_nx   = state;
    steps_nx   = steps;
    cur_sel_nx = cur_sel_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          steps_nx = sel_steps(bus.target, cur_sel_q);
          state_nx = (steps_nx == '0) ? DONE : HIGH;
        end
      end
      HIGH: begin
        if (timer_expire) begin
          cur_sel_nx = cur_sel_q + 1'b1;
          steps_nx   = steps - 1'b1;
          state_nx   = LOW;
        end
      end
      LOW: begin
        if (timer_expire) begin
          state_nx = (steps == '0 || stop_now) ? DONE : HIGH;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: reset is synchronous; it takes effect on the first edge that samples it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      steps     <= '0;
      cur_sel_q <= '0;
      btn_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      steps     <= steps_nx;
      cur_sel_q <= cur_sel_nx;
      btn_q     <= (state_nx == HIGH);
    end
  end

  assign bus.btn     = btn_q;
  assign bus.cur_sel = cur_sel_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);

endmodule

// File: doc/btn_pulse_gen.md
BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

Interface
REQ-001 Parameter HIGH_CYC, default 4: clock cycles btn is held high per press, legal range >= 1.
REQ-002 Parameter LOW_CYC, default 4: clock cycles btn is held low between presses, legal range >= 1.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to step the selector to target; sampled only in IDLE.
REQ-006 target  input  3  desired selector value; captured with an accepted start.
REQ-007 btn  output  1  registered button stimulus driven into the selector-control block.
REQ-008 cur_sel  output  3  mirror of the selector value the downstream block holds.
REQ-009 busy  output  1  high whenever state != IDLE.
REQ-010 done  output  1  one-cycle pulse when a request completes.

Function
REQ-011 FSM states SHALL be IDLE, HIGH, LOW and DONE.
REQ-012 IDLE + start=1 SHALL capture steps = (target - cur_sel) mod 8 (3-bit wrap subtract); the state is set on the next edge.
REQ-013 steps==0 on acceptance SHALL go IDLE->DONE with btn never asserted.
REQ-014 steps!=0 on acceptance SHALL go IDLE->HIGH; btn SHALL be 1 exactly HIGH_CYC cycles, starting the cycle after start.
REQ-015 The last HIGH cycle SHALL increment cur_sel (7 wraps to 0), decrement steps, and go to LOW.
REQ-016 LOW SHALL hold btn=0 exactly LOW_CYC cycles, then go to HIGH if steps!=0, else DONE.
REQ-017 DONE SHALL assert done=1 for one cycle and return to IDLE; busy=1 in DONE.
REQ-018 start SHALL be ignored in any state other than IDLE; target changes while busy SHALL have no effect.
REQ-019 start in the cycle DONE returns to IDLE SHALL NOT be accepted; acceptance needs IDLE at sampling.
REQ-020 A request of n presses SHALL keep busy high for n*(HIGH_CYC+LOW_CYC)+1 cycles.
REQ-021 The phase timer SHALL count 0..max(HIGH_CYC,LOW_CYC)-1 and clear on each phase change.

Reset
REQ-022 reset SHALL force IDLE, btn=0, busy=0, done=0, cur_sel=0, steps=0 and timer=0 at the next edge.
REQ-023 reset mid-sequence SHALL abort it with no done pulse; btn is 0 in the cycle after reset is sampled.

Configuration
REQ-024 With BTN_PULSE_GEN_ABORT_EN defined, an input port abort (1 bit) SHALL exist.
REQ-025 abort=1 in HIGH SHALL complete the current press and its LOW phase, then go to DONE; abort=1 in LOW SHALL go to DONE after the LOW phase.
REQ-026 Abort behaviour SHALL keep cur_sel consistent with presses actually issued.
REQ-027 abort in IDLE or DONE SHALL be ignored.
REQ-028 Without BTN_PULSE_GEN_ABORT_EN, the abort port and its logic SHALL be absent, and behaviour SHALL equal REQ-011..021.

Structure
REQ-029 Shared package btn_pkg SHALL hold SEL_W=3 and the FSM state typedef (IDLE, HIGH, LOW, DONE).
REQ-030 One sub-module, phase_timer (load/count/expire), SHALL time HIGH and LOW phases; all else stays in btn_pulse_gen.

Verification
REQ-031 Reset, then start with target=3 (defaults) -> 3 btn pulses of 4 high / 4 low; cur_sel 1,2,3; done 25 cycles after start; busy high 25 cycles.
REQ-032 cur_sel=6, start with target=1 -> 3 presses; cur_sel 7,0,1 (wrap); done asserted once.
REQ-033 cur_sel=5, start with target=5 -> no btn activity; done one cycle after acceptance; busy high 1 cycle.
REQ-034 start pulsed and target changed to 7 while busy on a target=2 request -> only 2 presses, cur_sel=2.
REQ-035 reset asserted during the 2nd HIGH phase -> btn=0 next cycle, cur_sel=0, no done pulse.
REQ-036 BTN_PULSE_GEN_ABORT_EN defined: abort during the 1st HIGH of a target=4 request -> exactly 1 full pulse, cur_sel=1, done once.
